// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style control FSM for a shared instruction/data memory.
// Sequences FETCH/DECODE/execute states, produces datapath selects and write
// enables, and halts on memory timeout.
// Optional build macro MC_ILLEGAL_HALT_EN: when defined, an unknown opcode in
// DECODE halts the machine and sets the sticky illegal_op flag; when undefined,
// unknown opcodes behave as NOPs and illegal_op is tied low.
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic [3:0] state,
    output logic       mem_err,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_JALRPC   = 4'd12,
        S_LUI      = 4'd13,
        S_UNUSED   = 4'd14,
        S_HALT     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_wait_cnt;
    logic       r_mem_err;
    logic       w_mem_state;
    logic       w_timeout;
    logic       w_mem_err_set;
    logic       w_pc_write;
    logic       w_ir_write;
    logic       w_mem_write;
    logic       w_reg_write;
    logic       w_adr_src;
    logic [1:0] w_result_src;
    logic [1:0] w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;
    logic       w_br_taken;
`ifdef MC_ILLEGAL_HALT_EN
    logic       r_illegal_op;
    logic       w_illegal_set;
`endif

    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                         (r_state == S_MEMWRITE);
    assign w_timeout   = (r_wait_cnt == LAST_WAIT) && !mem_ready;

    // Branch condition selected by funct3
    always_comb begin
        w_br_taken = 1'b0;
        case (funct3)
            3'b000:  w_br_taken = zero;
            3'b001:  w_br_taken = !zero;
            3'b100:  w_br_taken = lt;
            3'b101:  w_br_taken = !lt;
            default: w_br_taken = 1'b0;
        endcase
    end

    // State register, memory wait counter and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state <= w_next;
            // any state change clears the counter, so every entry into a
            // memory-wait state starts counting from zero
            if (w_next != r_state) begin
                r_wait_cnt <= '0;
            end else if (w_mem_state && !mem_ready) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
            if (w_mem_err_set) begin
                r_mem_err <= 1'b1;
            end
        end
    end

`ifdef MC_ILLEGAL_HALT_EN
    // Sticky illegal-opcode flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_illegal_op <= 1'b0;
        end else if (w_illegal_set) begin
            r_illegal_op <= 1'b1;
        end
    end
    assign illegal_op = r_illegal_op;
`else
    assign illegal_op = 1'b0;
`endif

    // Next-state and per-state datapath controls
    always_comb begin
        w_next        = r_state;
        w_mem_err_set = 1'b0;
        w_pc_write    = 1'b0;
        w_ir_write    = 1'b0;
        w_mem_write   = 1'b0;
        w_reg_write   = 1'b0;
        w_adr_src     = 1'b0;
        w_result_src  = 2'b00;
        w_alu_src_a   = 2'b00;
        w_alu_src_b   = 2'b00;
        w_alu_op      = 2'b00;
`ifdef MC_ILLEGAL_HALT_EN
        w_illegal_set = 1'b0;
`endif
        case (r_state)
            S_FETCH: begin
                w_adr_src    = 1'b0;
                w_alu_src_a  = 2'b00;
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
                w_alu_op     = 2'b00;
                w_ir_write   = mem_ready;
                w_pc_write   = mem_ready;
                if (mem_ready) begin
                    w_next = S_DECODE;
                end else if (w_timeout) begin
                    w_next        = S_HALT;
                    w_mem_err_set = 1'b1;
                end
            end
            S_DECODE: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b01;
                w_alu_op    = 2'b00;
                case (op)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_RTYPE:          w_next = S_EXECR;
                    OP_ITYPE:          w_next = S_EXECI;
                    OP_BR:             w_next = S_BRANCH;
                    OP_JAL:            w_next = S_JAL;
                    OP_JALR:           w_next = S_JALR;
                    OP_LUI:            w_next = S_LUI;
                    default: begin
`ifdef MC_ILLEGAL_HALT_EN
                        w_next        = S_HALT;
                        w_illegal_set = 1'b1;
`else
                        w_next = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_alu_op    = 2'b00;
                w_next      = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                w_adr_src = 1'b1;
                if (mem_ready) begin
                    w_next = S_MEMWB;
                end else if (w_timeout) begin
                    w_next        = S_HALT;
                    w_mem_err_set = 1'b1;
                end
            end
            S_MEMWB: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEMWRITE: begin
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
                if (mem_ready) begin
                    w_next = S_FETCH;
                end else if (w_timeout) begin
                    w_next        = S_HALT;
                    w_mem_err_set = 1'b1;
                end
            end
            S_EXECR: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b00;
                w_alu_op    = 2'b10;
                w_next      = S_ALUWB;
            end
            S_EXECI: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_alu_op    = 2'b10;
                w_next      = S_ALUWB;
            end
            S_ALUWB: begin
                w_result_src = 2'b00;
                w_reg_write  = 1'b1;
                w_next       = S_FETCH;
            end
            S_BRANCH: begin
                w_alu_src_a  = 2'b10;
                w_alu_src_b  = 2'b00;
                w_alu_op     = 2'b01;
                w_result_src = 2'b00;
                w_pc_write   = w_br_taken;
                w_next       = S_FETCH;
            end
            S_JAL: begin
                w_alu_src_a  = 2'b01;
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b00;
                w_pc_write   = 1'b1;
                w_next       = S_ALUWB;
            end
            S_JALR: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_alu_op    = 2'b00;
                w_next      = S_JALRPC;
            end
            S_JALRPC: begin
                w_alu_src_a  = 2'b01;
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b00;
                w_pc_write   = 1'b1;
                w_next       = S_ALUWB;
            end
            S_LUI: begin
                w_alu_src_a = 2'b11;
                w_alu_src_b = 2'b01;
                w_alu_op    = 2'b00;
                w_next      = S_ALUWB;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Immediate format depends only on the opcode, in every state
    always_comb begin
        ImmSrc = 3'b000;
        case (op)
            OP_ITYPE, OP_LOAD, OP_JALR: ImmSrc = 3'b000;
            OP_STORE:                   ImmSrc = 3'b001;
            OP_BR:                      ImmSrc = 3'b010;
            OP_LUI:                     ImmSrc = 3'b011;
            OP_JAL:                     ImmSrc = 3'b100;
            default:                    ImmSrc = 3'b000;
        endcase
    end

    // Write enables are suppressed combinationally while reset is held
    assign PCWrite   = w_pc_write  & ~rst;
    assign IRWrite   = w_ir_write  & ~rst;
    assign MemWrite  = w_mem_write & ~rst;
    assign RegWrite  = w_reg_write & ~rst;
    assign AdrSrc    = w_adr_src;
    assign ResultSrc = w_result_src;
    assign ALUSrcA   = w_alu_src_a;
    assign ALUSrcB   = w_alu_src_b;
    assign ALUOp     = w_alu_op;
    assign state     = r_state;
    assign mem_err   = r_mem_err;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios plus
// random opcode / mem_ready / reset stimulus against an instruction-level
// reference model that walks a per-instruction list of expected states.
module tb_multicycle_controller;

    localparam int TMO = 4;

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_I    = 7'b0010011;
    localparam logic [6:0] OPC_LUI  = 7'b0110111;
    localparam logic [6:0] OPC_LW   = 7'b0000011;
    localparam logic [6:0] OPC_SW   = 7'b0100011;
    localparam logic [6:0] OPC_BR   = 7'b1100011;
    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       zero, lt, mem_ready;
    logic       PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [2:0] ImmSrc;
    logic [3:0] state;
    logic       mem_err, illegal_op;

    multicycle_controller #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .zero(zero), .lt(lt),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .AdrSrc(AdrSrc),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .ImmSrc(ImmSrc), .state(state), .mem_err(mem_err),
        .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    int m_state = 0;
    int m_wait  = 0;
    int m_plan[$];
    bit m_err = 1'b0;
    bit m_ill = 1'b0;

    // States visited after FETCH for one instruction; an empty list returns to FETCH
    function automatic void build_plan(input logic [6:0] o);
        case (o)
            OPC_R:    m_plan = {1, 6, 8};
            OPC_I:    m_plan = {1, 7, 8};
            OPC_LUI:  m_plan = {1, 13, 8};
            OPC_LW:   m_plan = {1, 2, 3, 4};
            OPC_SW:   m_plan = {1, 2, 5};
            OPC_BR:   m_plan = {1, 9};
            OPC_JAL:  m_plan = {1, 10, 8};
            OPC_JALR: m_plan = {1, 11, 12, 8};
`ifdef MC_ILLEGAL_HALT_EN
            default:  m_plan = {1, 15};
`else
            default:  m_plan = {1};
`endif
        endcase
    endfunction

    function automatic logic [2:0] exp_imm(input logic [6:0] o);
        if (o == OPC_SW)  return 3'b001;
        if (o == OPC_BR)  return 3'b010;
        if (o == OPC_LUI) return 3'b011;
        if (o == OPC_JAL) return 3'b100;
        return 3'b000;
    endfunction

    // {PCWrite,IRWrite,MemWrite,RegWrite,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUOp}
    function automatic logic [12:0] exp_ctl(input int s, input logic r, input logic mr,
                                            input logic [2:0] f3, input logic z, input logic l);
        logic [8:0] sel;
        logic [3:0] we;
        logic       taken;
        taken = (f3 == 3'd0 && z) || (f3 == 3'd1 && !z) ||
                (f3 == 3'd4 && l) || (f3 == 3'd5 && !l);
        sel = 9'd0;
        we  = 4'd0;
        case (s)
            0:  begin sel = 9'b0_10_00_10_00; we = {mr, mr, 2'b00}; end
            1:  sel = 9'b0_00_01_01_00;
            2:  sel = 9'b0_00_10_01_00;
            3:  sel = 9'b1_00_00_00_00;
            4:  begin sel = 9'b0_01_00_00_00; we = 4'b0001; end
            5:  begin sel = 9'b1_00_00_00_00; we = 4'b0010; end
            6:  sel = 9'b0_00_10_00_10;
            7:  sel = 9'b0_00_10_01_10;
            8:  we = 4'b0001;
            9:  begin sel = 9'b0_00_10_00_01; we = {taken, 3'b000}; end
            10: begin sel = 9'b0_00_01_10_00; we = 4'b1000; end
            11: sel = 9'b0_00_10_01_00;
            12: begin sel = 9'b0_00_01_10_00; we = 4'b1000; end
            13: sel = 9'b0_00_11_01_00;
            default: sel = 9'd0;
        endcase
        if (r) we = 4'b0000;
        return {we, sel};
    endfunction

    function automatic void model_step(input logic r, input logic mr);
        if (r) begin
            m_state = 0; m_wait = 0; m_plan.delete(); m_err = 1'b0; m_ill = 1'b0;
            return;
        end
        if (m_state == 15) return;
        if ((m_state == 0 || m_state == 3 || m_state == 5) && !mr) begin
            m_wait++;
            if (m_wait == TMO) begin
                m_state = 15; m_err = 1'b1;
            end
            return;
        end
        if (m_state == 0) build_plan(op);
        m_wait = 0;
        if (m_plan.size() > 0) begin
            m_state = m_plan.pop_front();
            if (m_state == 15) m_ill = 1'b1;
        end else begin
            m_state = 0;
        end
    endfunction

    // One clock: drive rst/mem_ready at the falling edge, compare shortly after,
    // advance the model, then wait for the next falling edge.
    task automatic cycle(input logic r, input logic mr);
        rst = r;
        mem_ready = mr;
        #1;
        check("state", 32'(state), m_state);
        check("ctl", 32'({PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ResultSrc,
                          ALUSrcA, ALUSrcB, ALUOp}),
              32'(exp_ctl(m_state, r, mr, funct3, zero, lt)));
        check("imm", 32'(ImmSrc), 32'(exp_imm(op)));
        check("flags", 32'({mem_err, illegal_op}), 32'({m_err, m_ill}));
        model_step(r, mr);
        @(negedge clk);
    endtask

    task automatic run_latency(input logic [6:0] o, input int exp_lat, input string tag);
        int n;
        op = o;
        cycle(1'b1, 1'b1);
        n = 0;
        do begin
            cycle(1'b0, 1'b1);
            n++;
        end while (state != 4'd0 && n < 20);
        check(tag, 32'(n), 32'(exp_lat));
    endtask

    logic [6:0] ops [10] = '{OPC_R, OPC_I, OPC_LUI, OPC_LW, OPC_SW, OPC_BR,
                             OPC_JAL, OPC_JALR, 7'b1111111, 7'b0000000};

    initial begin
        rst = 1'b1; mem_ready = 1'b1; op = OPC_R; funct3 = 3'd0; zero = 1'b0; lt = 1'b0;
        @(negedge clk);

        // reset state
        cycle(1'b1, 1'b1);
        check("rst_state", 32'(state), 32'd0);

        // latencies with memory always ready
        funct3 = 3'd2;
        run_latency(OPC_R,    4, "lat_r");
        run_latency(OPC_I,    4, "lat_i");
        run_latency(OPC_LUI,  4, "lat_lui");
        run_latency(OPC_LW,   5, "lat_lw");
        run_latency(OPC_SW,   4, "lat_sw");
        run_latency(OPC_BR,   3, "lat_br");
        run_latency(OPC_JAL,  4, "lat_jal");
        run_latency(OPC_JALR, 5, "lat_jalr");

        // load with three wait cycles in MEMREAD
        op = OPC_LW;
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b1); cycle(1'b0, 1'b1); cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0); cycle(1'b0, 1'b0); cycle(1'b0, 1'b0); cycle(1'b0, 1'b1);
        check("lw_wb_state", 32'(state), 32'd4);
        cycle(1'b0, 1'b1);

        // branch-not-equal with zero low then high
        op = OPC_BR; funct3 = 3'd1;
        for (int k = 0; k < 2; k++) begin
            zero = (k == 1);
            cycle(1'b1, 1'b1);
            cycle(1'b0, 1'b1); cycle(1'b0, 1'b1);
            rst = 1'b0; mem_ready = 1'b1; #1;
            check("bne_pcwrite", 32'(PCWrite), (k == 0) ? 32'd1 : 32'd0);
            cycle(1'b0, 1'b1);
        end

        // FETCH timeout boundary: ready on the last allowed cycle wins
        op = OPC_R;
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b0); cycle(1'b0, 1'b0); cycle(1'b0, 1'b0); cycle(1'b0, 1'b1);
        check("tmo_edge_state", 32'(state), 32'd1);

        // FETCH timeout, then reset recovery
        cycle(1'b1, 1'b1);
        for (int k = 0; k < TMO; k++) cycle(1'b0, 1'b0);
        check("tmo_state", 32'(state), 32'd15);
        check("tmo_err", 32'(mem_err), 32'd1);
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b0);
        check("tmo_rst_state", 32'(state), 32'd0);
        check("tmo_rst_err", 32'(mem_err), 32'd0);

        // unknown opcode
        op = 7'b1111111;
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b1); cycle(1'b0, 1'b1);
`ifdef MC_ILLEGAL_HALT_EN
        check("ill_state", 32'(state), 32'd15);
        check("ill_flag", 32'(illegal_op), 32'd1);
`else
        check("ill_state", 32'(state), 32'd0);
        check("ill_flag", 32'(illegal_op), 32'd0);
`endif
        cycle(1'b0, 1'b1);

        // reset in the middle of a stalled store
        op = OPC_SW;
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b1); cycle(1'b0, 1'b1); cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        rst = 1'b1; mem_ready = 1'b0; #1;
        check("rst_mw_memwrite", 32'(MemWrite), 32'd0);
        cycle(1'b1, 1'b0);
        check("rst_mw_state", 32'(state), 32'd0);

        // random traffic
        cycle(1'b1, 1'b1);
        for (int c = 0; c < 3000; c++) begin
            if (m_state == 0 && m_wait == 0) op = ops[$urandom_range(0, 9)];
            funct3 = 3'($urandom_range(0, 7));
            zero   = 1'($urandom);
            lt     = 1'($urandom);
            cycle(($urandom_range(0, 99) == 0) || (m_state == 15 && $urandom_range(0, 3) == 0),
                  $urandom_range(0, 3) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16, max cycles a memory state waits for mem_ready (legal range 2..255).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 op  in  7  opcode of the held instruction register; funct3  in  3  branch condition select.
REQ-005 zero  in  1  ALU result == 0; lt  in  1  ALU signed less-than flag.
REQ-006 mem_ready  in  1  shared instruction/data memory has completed the current access.
REQ-007 PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc  out  1 each  PC load, IR load, memory write, register-file write, address select (0=PC, 1=ALUOut).
REQ-008 ResultSrc  out  2  (00 ALUOut, 01 memory data, 10 ALU result); ALUSrcA  out  2  (00 PC, 01 OldPC, 10 rs1, 11 zero); ALUSrcB  out  2  (00 rs2, 01 imm, 10 const 4).
REQ-009 ALUOp  out  2  (00 add, 01 compare/sub, 10 funct-decoded); ImmSrc  out  3  immediate format.
REQ-010 state  out  4  current state encoding; mem_err  out  1  sticky timeout flag; illegal_op  out  1  sticky illegal-opcode flag.

Function
REQ-011 States/encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, JALR 11, JALRPC 12, LUI 13, HALT 15; code 14 unused -> FETCH next cycle.
REQ-012 ImmSrc combinational from op in every state: 0010011/0000011/1100111 -> 000, 0100011 -> 001, 1100011 -> 010, 0110111 -> 011, 1101111 -> 100, else 000.
REQ-013 Every output not listed for a state SHALL be 0.
REQ-014 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, ALUOp=00; IRWrite=PCWrite=mem_ready; -> DECODE when mem_ready, else stay.
REQ-015 DECODE (1 cycle): ALUSrcA=01, ALUSrcB=01, ALUOp=00; next by op: LW/SW -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1100011 -> BRANCH, 1101111 -> JAL, 1100111 -> JALR, 0110111 -> LUI, other -> see REQ-030.
REQ-016 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; -> MEMREAD if op=0000011, else MEMWRITE.
REQ-017 MEMREAD: AdrSrc=1; -> MEMWB on mem_ready. MEMWB: ResultSrc=01, RegWrite=1; -> FETCH.
REQ-018 MEMWRITE: AdrSrc=1, MemWrite=1 held until mem_ready; -> FETCH on mem_ready.
REQ-019 EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Both -> ALUWB.
REQ-020 ALUWB: ResultSrc=00, RegWrite=1; -> FETCH.
REQ-021 BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00; PCWrite = zero (funct3 000), !zero (001), lt (100), !lt (101), 0 otherwise; -> FETCH.
REQ-022 JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCWrite=1; -> ALUWB.
REQ-023 JALR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; -> JALRPC. JALRPC: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCWrite=1; -> ALUWB.
REQ-024 LUI: ALUSrcA=11, ALUSrcB=01, ALUOp=00; -> ALUWB.
REQ-025 Wait counter: 8 bits, cleared on every entry to FETCH/MEMREAD/MEMWRITE, increments each cycle mem_ready=0 in those states.
REQ-026 If counter = MEM_TIMEOUT-1 and mem_ready=0 -> HALT, mem_err=1; mem_ready=1 on that same cycle wins (normal transition).
REQ-027 HALT: all write enables 0; remains until rst.
REQ-028 Latencies (mem_ready=1 throughout): R/I/LUI 4 cycles, LW 5, SW 4, branch 3, JAL 4, JALR 5.

Reset
REQ-029 rst sampled high: state<=FETCH, counter<=0, mem_err<=0, illegal_op<=0; PCWrite, IRWrite, MemWrite, RegWrite forced 0 combinationally while rst=1, including mid-instruction.

Configuration
REQ-030 Macro MC_ILLEGAL_HALT_EN: defined -> unknown opcode in DECODE goes to HALT, illegal_op=1; undefined -> unknown opcode treated as NOP (DECODE -> FETCH), illegal_op tied 0.

Verification
REQ-031 op=0110011, mem_ready=1 -> states 0,1,6,8,0; RegWrite=1 only in state 8, ALUOp=10 in state 6.
REQ-032 op=0000011, mem_ready low 3 cycles in MEMREAD -> state 3 held 4 cycles, then 4 with ResultSrc=01, RegWrite=1.
REQ-033 op=1100011, funct3=001, zero=0 -> PCWrite=1 in BRANCH; zero=1 -> PCWrite=0.
REQ-034 MEM_TIMEOUT=4, mem_ready=0 in FETCH -> state 15, mem_err=1 after 4 FETCH cycles; rst -> state 0, mem_err=0.
REQ-035 op=1111111 with MC_ILLEGAL_HALT_EN -> state 15, illegal_op=1; without -> states 0,1,0, illegal_op=0.
REQ-036 rst asserted during MEMWRITE with mem_ready=0 -> MemWrite=0 same cycle, state 0 next cycle.
